// File: rtl/ep_host_initiator_pkg.sv
// ep_host_initiator_pkg: shared definitions for the endpoint-bus host initiator.
//   - command op codes, controller states
//   - wire-in / wire-out base addresses, data width
//   - idx_w(): index width for an N-entry table (at least 1 bit)
package ep_host_initiator_pkg;

    localparam int         DW           = 32;
    localparam logic [7:0] WIREIN_BASE  = 8'h00;
    localparam logic [7:0] WIREOUT_BASE = 8'h20;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'd0,
        OP_READ       = 2'd1,
        OP_UPDATE_IN  = 2'd2,
        OP_UPDATE_OUT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_PULL  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ep_host_initiator_shadow_regfile.sv
// ep_shadow_regfile: N x 32 wire-in shadow storage with per-entry dirty bits.
//   okClk, rst_n        clock, async active-low reset (clears data and dirty)
//   wr_en/wr_idx/wr_data  staging write, sets the entry's dirty bit
//   clr_en/clr_idx      clear dirty bit of the entry being pushed
//   rd_idx/rd_data      combinational indexed read
//   dirty               dirty vector (all zero unless EP_HOST_DIRTY_ONLY_EN)
// Macro EP_HOST_DIRTY_ONLY_EN: implements the dirty bits.
module ep_shadow_regfile
    import ep_host_initiator_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                   okClk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [idx_w(N)-1:0]    wr_idx,
    input  logic [DW-1:0]          wr_data,
    input  logic                   clr_en,
    input  logic [idx_w(N)-1:0]    clr_idx,
    input  logic [idx_w(N)-1:0]    rd_idx,
    output logic [DW-1:0]          rd_data,
    output logic [N-1:0]           dirty
);

    logic [DW-1:0] mem [N];

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

`ifdef EP_HOST_DIRTY_ONLY_EN
    // Writes and pushes never coincide (commands are serialized), so order is moot.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= '0;
        end else begin
            if (clr_en) dirty[clr_idx] <= 1'b0;
            if (wr_en)  dirty[wr_idx]  <= 1'b1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = ^{clr_en, clr_idx};
    assign dirty      = '0;
`endif

endmodule

// File: rtl/ep_host_initiator.sv
// ep_host_initiator: host-side initiator for wire-in / wire-out endpoints.
//   okClk, rst_n     clock, async active-low reset
//   cmd_*            valid/ready command port (WRITE, READ, UPDATE_IN, UPDATE_OUT)
//   rsp_*            one-cycle response pulse (READ data, range error)
//   ep_*             endpoint bus: ep_we pushes wire-ins, ep_re pulls wire-outs,
//                    ep_rdata returns one cycle after ep_re
//   busy             controller not idle
// WRITEs stage into shadow registers; UPDATE_IN commits them in one sweep.
// UPDATE_OUT snapshots every wire-out so READs see one coherent set.
// Macro EP_HOST_DIRTY_ONLY_EN: UPDATE_IN pushes only entries written since
// their last push.
module ep_host_initiator
    import ep_host_initiator_pkg::*;
#(
    parameter int N_WIRE_IN  = 3,
    parameter int N_WIRE_OUT = 2
) (
    input  logic          okClk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [7:0]    ep_addr,
    output logic          ep_we,
    output logic [DW-1:0] ep_wdata,
    output logic          ep_re,
    input  logic [DW-1:0] ep_rdata,
    output logic          busy
);

    localparam int         IIW = idx_w(N_WIRE_IN);
    localparam int         OIW = idx_w(N_WIRE_OUT);
    localparam logic [7:0] NI  = 8'(N_WIRE_IN);
    localparam logic [7:0] NO  = 8'(N_WIRE_OUT);

    state_e          state;
    logic [4:0]      idx;        // current push / pull index
    logic            cap_vld;    // ep_rdata for cap_idx arrives this cycle
    logic [OIW-1:0]  cap_idx;
    logic [DW-1:0]   snap [N_WIRE_OUT];

    logic            accept;
    logic [7:0]      ro_off;
    logic            rd_ok;
    logic [DW-1:0]   sh_rd;
    logic [N_WIRE_IN-1:0] dirty, push_mask;
    logic [5:0]      start;
    logic            nxt_found;
    logic [4:0]      nxt_idx;
    logic            push_fire;

    assign accept = cmd_valid && cmd_ready;
    // Addresses below the wire-out base wrap to large offsets and fail the check.
    assign ro_off = cmd_addr - WIREOUT_BASE;
    assign rd_ok  = ro_off < NO;

`ifdef EP_HOST_DIRTY_ONLY_EN
    assign push_mask = dirty;
`else
    logic unused_dirty;
    assign unused_dirty = ^dirty;
    assign push_mask    = '1;
`endif

    // Next wire-in to push: lowest eligible index at or above start.
    assign start = (state == S_IDLE) ? 6'd0 : ({1'b0, idx} + 6'd1);

    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = N_WIRE_IN - 1; i >= 0; i--) begin
            if (i >= int'(start) && push_mask[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = 5'(i);
            end
        end
    end

    assign push_fire = nxt_found &&
                       ((accept && op_e'(cmd_op) == OP_UPDATE_IN) || state == S_PUSH);

    ep_shadow_regfile #(.N(N_WIRE_IN)) u_shadow (
        .okClk   (okClk),
        .rst_n   (rst_n),
        .wr_en   (accept && op_e'(cmd_op) == OP_WRITE && cmd_addr < NI),
        .wr_idx  (cmd_addr[IIW-1:0]),
        .wr_data (cmd_wdata),
        .clr_en  (push_fire),
        .clr_idx (nxt_idx[IIW-1:0]),
        .rd_idx  (nxt_idx[IIW-1:0]),
        .rd_data (sh_rd),
        .dirty   (dirty)
    );

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ep_addr   <= '0;
            ep_we     <= 1'b0;
            ep_wdata  <= '0;
            ep_re     <= 1'b0;
            idx       <= '0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            for (int j = 0; j < N_WIRE_OUT; j++) snap[j] <= '0;
        end else begin
            // Bus and response outputs are single-cycle unless re-asserted below.
            ep_we     <= 1'b0;
            ep_re     <= 1'b0;
            ep_addr   <= '0;
            ep_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cap_vld   <= 1'b0;
            if (cap_vld) snap[cap_idx] <= ep_rdata;

            case (state)
                S_IDLE: if (accept) begin
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= !(cmd_addr < NI);
                        end
                        OP_READ: begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            if (rd_ok) rsp_data <= snap[ro_off[OIW-1:0]];
                            else       rsp_err  <= 1'b1;
                        end
                        OP_UPDATE_IN: begin
                            if (nxt_found) begin
                                state    <= S_PUSH;
                                idx      <= nxt_idx;
                                ep_we    <= 1'b1;
                                ep_addr  <= WIREIN_BASE + 8'(nxt_idx);
                                ep_wdata <= sh_rd;
                            end else begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= S_PULL;
                            idx     <= '0;
                            ep_re   <= 1'b1;
                            ep_addr <= WIREOUT_BASE;
                        end
                    endcase
                end
                S_PUSH: begin
                    if (nxt_found) begin
                        idx      <= nxt_idx;
                        ep_we    <= 1'b1;
                        ep_addr  <= WIREIN_BASE + 8'(nxt_idx);
                        ep_wdata <= sh_rd;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                S_PULL: begin
                    // Strobe for idx is on the bus now; its data lands next cycle.
                    cap_vld <= 1'b1;
                    cap_idx <= idx[OIW-1:0];
                    if (8'(idx) + 8'd1 < NO) begin
                        idx     <= idx + 5'd1;
                        ep_re   <= 1'b1;
                        ep_addr <= WIREOUT_BASE + 8'(idx) + 8'd1;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ep_host_initiator.sv
// Self-checking bench for ep_host_initiator (N_WIRE_IN=3, N_WIRE_OUT=2).
// Directed vector table, hand-written reset / coherence / dirty-only sequences,
// then randomized commands against a behavioural model of the host view.
module tb_ep_host_initiator;

    localparam int NI = 3;
    localparam int NO = 2;
`ifdef EP_HOST_DIRTY_ONLY_EN
    localparam bit DONLY = 1'b1;
`else
    localparam bit DONLY = 1'b0;
`endif

    logic        okClk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_addr = 8'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  ep_addr;
    logic        ep_we;
    logic [31:0] ep_wdata;
    logic        ep_re;
    logic [31:0] ep_rdata = 32'd0;
    logic        busy;

    ep_host_initiator #(.N_WIRE_IN(NI), .N_WIRE_OUT(NO)) dut (
        .okClk(okClk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ep_addr(ep_addr), .ep_we(ep_we), .ep_wdata(ep_wdata),
        .ep_re(ep_re), .ep_rdata(ep_rdata), .busy(busy)
    );

    always #5 okClk = ~okClk;

    // Wire-out endpoint model: registered read, garbage when not strobed.
    logic [31:0] wo_val [NO];
    always @(posedge okClk) begin
        if (ep_re && int'(ep_addr) >= 32 && int'(ep_addr) < 32 + NO)
            ep_rdata <= wo_val[int'(ep_addr) - 32];
        else
            ep_rdata <= $urandom;
    end

    typedef struct packed {
        logic [7:0]  t;
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } stb_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wd;
        int          lat;
        bit          err;
        logic [31:0] data;
        int          nstb;
    } vec_t;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model of what the host should see.
    logic [31:0] m_sh [NI];
    bit          m_dirty [NI];
    logic [31:0] m_snap [NO];
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_data;
    stb_t        exp_q [$];

    // Observed results of the last command.
    int          obs_lat;
    bit          obs_err;
    logic [31:0] obs_data;
    bit          obs_ok;
    stb_t        obs_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin m_sh[i] = '0; m_dirty[i] = 1'b0; end
        for (int j = 0; j < NO; j++) m_snap[j] = '0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd);
        stb_t s;
        int   n;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_data = '0;
        exp_lat  = 1;
        case (op)
            2'd0: if (int'(addr) < NI) begin
                      m_sh[int'(addr)] = wd; m_dirty[int'(addr)] = 1'b1;
                  end else exp_err = 1'b1;
            2'd1: if (int'(addr) >= 32 && int'(addr) < 32 + NO) exp_data = m_snap[int'(addr) - 32];
                  else exp_err = 1'b1;
            2'd2: begin
                n = 0;
                for (int k = 0; k < NI; k++) begin
                    if (!DONLY || m_dirty[k]) begin
                        n++;
                        s.t = 8'(n); s.we = 1'b1; s.re = 1'b0; s.addr = 8'(k); s.wdata = m_sh[k];
                        exp_q.push_back(s);
                        m_dirty[k] = 1'b0;
                    end
                end
                exp_lat = n + 1;
            end
            default: begin
                for (int j = 0; j < NO; j++) begin
                    s.t = 8'(j + 1); s.we = 1'b0; s.re = 1'b1; s.addr = 8'(32 + j); s.wdata = '0;
                    exp_q.push_back(s);
                    m_snap[j] = wo_val[j];
                end
                exp_lat = NO + 2;
            end
        endcase
    endtask

    // Issue one command and record everything seen until the response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd);
        bit   ok;
        stb_t s;
        ok = 1'b1;
        obs_q.delete();
        obs_lat = -1; obs_err = 1'b0; obs_data = '0;
        @(negedge okClk);
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        @(posedge okClk);
        for (int t = 1; t <= 60; t++) begin
            @(negedge okClk);
            // Noise on the command port while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            if (ep_we === 1'b1 && ep_re === 1'b1) ok = 1'b0;
            if (ep_we === 1'b1 || ep_re === 1'b1) begin
                s.t = 8'(t); s.we = ep_we; s.re = ep_re; s.addr = ep_addr; s.wdata = ep_wdata;
                obs_q.push_back(s);
            end else if (ep_addr !== 8'd0 || ep_wdata !== 32'd0 || ep_we !== 1'b0 || ep_re !== 1'b0) begin
                ok = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                obs_lat = t; obs_err = rsp_err; obs_data = rsp_data;
                break;
            end else if (rsp_err !== 1'b0 || rsp_data !== 32'd0) begin
                ok = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        obs_ok = ok;
    endtask

    task automatic cmp_strobes(input string name);
        chk({name, " nstb"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s stb%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    task automatic model_check(input string name, input logic [1:0] op,
                               input logic [7:0] addr, input logic [31:0] wd);
        model_cmd(op, addr, wd);
        run_cmd(op, addr, wd);
        chk({name, " lat"}, 64'(obs_lat), 64'(exp_lat));
        chk({name, " err"}, 64'(obs_err), 64'(exp_err));
        chk({name, " data"}, 64'(obs_data), 64'(exp_data));
        chk({name, " proto"}, 64'(obs_ok), 64'd1);
        cmp_strobes(name);
    endtask

    vec_t tv [10];

    initial begin
        wo_val[0] = 32'hDEADBEEF;
        wo_val[1] = 32'h0000000C;
        model_reset();

        // Directed vectors: {op, addr, wdata, latency, err, data, strobes}
        tv[0] = '{2'd0, 8'h01, 32'h5,    1, 1'b0, 32'h0, 0};
        tv[1] = '{2'd0, 8'h02, 32'h7,    1, 1'b0, 32'h0, 0};
        tv[2] = '{2'd2, 8'h00, 32'h0,    DONLY ? 3 : 4, 1'b0, 32'h0, DONLY ? 2 : 3};
        tv[3] = '{2'd3, 8'h00, 32'h0,    4, 1'b0, 32'h0, 2};
        tv[4] = '{2'd1, 8'h21, 32'h0,    1, 1'b0, 32'h0000000C, 0};
        tv[5] = '{2'd1, 8'h20, 32'h0,    1, 1'b0, 32'hDEADBEEF, 0};
        tv[6] = '{2'd0, 8'h05, 32'h1234, 1, 1'b1, 32'h0, 0};
        tv[7] = '{2'd1, 8'h30, 32'h0,    1, 1'b1, 32'h0, 0};
        tv[8] = '{2'd1, 8'h01, 32'h0,    1, 1'b1, 32'h0, 0};
        tv[9] = '{2'd2, 8'h00, 32'h0,    DONLY ? 1 : 4, 1'b0, 32'h0, DONLY ? 0 : 3};

        repeat (3) @(negedge okClk);
        chk("reset outputs",
            {cmd_ready, busy, rsp_valid, rsp_err, ep_we, ep_re, ep_addr, ep_wdata, rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0});
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            model_cmd(tv[i].op, tv[i].addr, tv[i].wd);
            run_cmd(tv[i].op, tv[i].addr, tv[i].wd);
            chk($sformatf("vec%0d lat", i),   64'(obs_lat),  64'(tv[i].lat));
            chk($sformatf("vec%0d err", i),   64'(obs_err),  64'(tv[i].err));
            chk($sformatf("vec%0d data", i),  64'(obs_data), 64'(tv[i].data));
            chk($sformatf("vec%0d proto", i), 64'(obs_ok),   64'd1);
            chk($sformatf("vec%0d nstb", i),  64'(obs_q.size()), 64'(tv[i].nstb));
            cmp_strobes($sformatf("vec%0d", i));
        end

        // Snapshot stays put when the endpoints change without a new sweep.
        wo_val[0] = 32'h11112222;
        wo_val[1] = 32'h33334444;
        run_cmd(2'd1, 8'h20, 32'h0);
        chk("coherent 0x20", 64'(obs_data), 64'hDEADBEEF);
        run_cmd(2'd1, 8'h21, 32'h0);
        chk("coherent 0x21", 64'(obs_data), 64'h0000000C);

        // Reset in the middle of a full push sweep.
        model_check("pre wr", 2'd0, 8'h00, 32'hAA);
        model_check("pre wr1", 2'd0, 8'h01, 32'hBB);
        @(negedge okClk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 8'h00; cmd_wdata = '0;
        @(posedge okClk);
        @(negedge okClk);
        cmd_valid = 1'b0;
        @(posedge okClk);
        #2;
        chk("mid push strobe", {ep_we, ep_addr}, {1'b1, 8'h01});
        rst_n = 1'b0;
        #1;
        chk("async reset outputs",
            {cmd_ready, busy, rsp_valid, rsp_err, ep_we, ep_re, ep_addr, ep_wdata, rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0});
        @(negedge okClk);
        @(negedge okClk);
        rst_n = 1'b1;
        model_reset();
        chk("ready after reset", 64'(cmd_ready), 64'd1);
        model_check("post rst upd_in", 2'd2, 8'h00, 32'h0);
        model_check("post rst read", 2'd1, 8'h20, 32'h0);

        if (DONLY) begin
            model_check("donly wr", 2'd0, 8'h02, 32'h11);
            model_check("donly upd1", 2'd2, 8'h00, 32'h0);
            chk("donly upd1 lat", 64'(obs_lat), 64'd2);
            model_check("donly upd2", 2'd2, 8'h00, 32'h0);
            chk("donly upd2 lat", 64'(obs_lat), 64'd1);
        end

        // Randomized commands against the model.
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  op;
            logic [7:0]  addr;
            int          sel;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            case (sel)
                0: addr = 8'($urandom_range(0, NI - 1));
                1: addr = 8'(32 + $urandom_range(0, NO - 1));
                2: addr = 8'($urandom);
                default: case ($urandom_range(0, 2))
                    0: addr = 8'(NI);
                    1: addr = 8'h1F;
                    default: addr = 8'(32 + NO);
                endcase
            endcase
            if ($urandom_range(0, 4) == 0)
                for (int j = 0; j < NO; j++) wo_val[j] = $urandom;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge okClk);
            model_check($sformatf("rnd%0d", n), op, addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
